// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the NES CPU bus front-end.
// Holds the bus-cycle FSM encoding, default parameter values and field widths.
package cpu_bus_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int M2_FILT_DEF     = 3;
  localparam int WR_DLY_DEF      = 4;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int GCNT_W = 8;
  localparam int DLY_W  = 4;
  localparam int FILT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HI_RD    = 2'd1,
    ST_HI_WR    = 2'd2,
    ST_HI_WDONE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/sig_filt.sv
// Single-bit synchronizer followed by a level debounce filter.
// rise_o/fall_o/glitch_o describe what happens on the coming clock edge so callers can register strobes aligned with filt_o.
module sig_filt
  import cpu_bus_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT        = M2_FILT_DEF,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o,
  output logic glitch_o
);

  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sig_s;

  assign sig_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d    = cnt_q;
    filt_d   = filt_q;
    glitch_o = 1'b0;
    if (sig_s != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = ~filt_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      // level went back before it was accepted
      cnt_d    = '0;
      glitch_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_d & ~filt_q;
  assign fall_o = ~filt_d & filt_q;

endmodule

// File: rtl/cpu_bus_sync.sv
// NES CPU bus front-end: synchronizes M2/address/data/R-W into the clk domain
// and produces a latched cycle snapshot, single-cycle strobes and cycle counters.
module cpu_bus_sync
  import cpu_bus_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int M2_FILT     = M2_FILT_DEF,
  parameter int WR_DLY      = WR_DLY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m2_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [DATA_W-1:0] cpu_dat_in,
  input  logic              cpu_rw_in,
  output logic              m2_f,
  output logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rw,
  output logic [DATA_W-1:0] cpu_dat,
  output logic              cyc_start,
  output logic              rd_stb,
  output logic              wr_stb,
  output logic              cyc_end,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [GCNT_W-1:0] glitch_cnt
);

  localparam int              BUS_W    = ADDR_W + DATA_W + 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(WR_DLY);

  logic m2_rise, m2_fall, m2_glitch;

  sig_filt #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT        (M2_FILT),
    .RST_VAL     (1'b1)
  ) u_m2_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (m2_in),
    .filt_o   (m2_f),
    .rise_o   (m2_rise),
    .fall_o   (m2_fall),
    .glitch_o (m2_glitch)
  );

  // Bus fields share one chain so they stay aligned with each other and with M2.
  logic [BUS_W-1:0]  bus_sync_q [SYNC_STAGES];
  logic [BUS_W-1:0]  bus_sync_d [SYNC_STAGES];
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dat_q;
  logic              rw_q;

  always_comb begin
    bus_sync_d[0] = {cpu_rw_in, cpu_dat_in, cpu_addr_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      bus_sync_d[i] = bus_sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sync_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        bus_sync_q[i] <= bus_sync_d[i];
      end
    end
  end

  assign {rw_q, dat_q, addr_q} = bus_sync_q[SYNC_STAGES-1];

  bus_state_e        state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d, dly_inc;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic              cpu_rw_q, cpu_rw_d;
  logic [DATA_W-1:0] cpu_dat_q, cpu_dat_d;
  logic              cyc_start_q, cyc_start_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic              cyc_end_q, cyc_end_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [GCNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  assign dly_inc = dly_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    cpu_addr_d   = cpu_addr_q;
    cpu_rw_d     = cpu_rw_q;
    cpu_dat_d    = cpu_dat_q;
    cyc_start_d  = 1'b0;
    rd_stb_d     = 1'b0;
    wr_stb_d     = 1'b0;
    cyc_end_d    = 1'b0;
    cyc_cnt_d    = cyc_cnt_q;
    glitch_cnt_d = glitch_cnt_q;

    if (m2_glitch && (glitch_cnt_q != '1)) begin
      glitch_cnt_d = glitch_cnt_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (m2_rise) begin
          cpu_addr_d  = addr_q;
          cpu_rw_d    = rw_q;
          cyc_start_d = 1'b1;
          dly_d       = '0;
          if (rw_q) begin
            rd_stb_d = 1'b1;
            state_d  = ST_HI_RD;
          end else begin
            state_d = ST_HI_WR;
          end
        end
      end
      ST_HI_WR: begin
        // An early fall wins over the delay match; the write is flushed with cyc_end.
        if (m2_fall) begin
          cpu_dat_d = dat_q;
          wr_stb_d  = 1'b1;
          cyc_end_d = 1'b1;
          cyc_cnt_d = cyc_cnt_q + 1'b1;
          state_d   = ST_IDLE;
        end else begin
          dly_d = dly_inc;
          if (dly_inc == DLY_LAST) begin
            cpu_dat_d = dat_q;
            wr_stb_d  = 1'b1;
            state_d   = ST_HI_WDONE;
          end
        end
      end
      ST_HI_RD, ST_HI_WDONE: begin
        if (m2_fall) begin
          cyc_end_d = 1'b1;
          cyc_cnt_d = cyc_cnt_q + 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      dly_q        <= '0;
      cpu_addr_q   <= '0;
      cpu_rw_q     <= 1'b1;
      cpu_dat_q    <= '0;
      cyc_start_q  <= 1'b0;
      rd_stb_q     <= 1'b0;
      wr_stb_q     <= 1'b0;
      cyc_end_q    <= 1'b0;
      cyc_cnt_q    <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      dly_q        <= dly_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_rw_q     <= cpu_rw_d;
      cpu_dat_q    <= cpu_dat_d;
      cyc_start_q  <= cyc_start_d;
      rd_stb_q     <= rd_stb_d;
      wr_stb_q     <= wr_stb_d;
      cyc_end_q    <= cyc_end_d;
      cyc_cnt_q    <= cyc_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign cpu_addr   = cpu_addr_q;
  assign cpu_rw     = cpu_rw_q;
  assign cpu_dat    = cpu_dat_q;
  assign cyc_start  = cyc_start_q;
  assign rd_stb     = rd_stb_q;
  assign wr_stb     = wr_stb_q;
  assign cyc_end    = cyc_end_q;
  assign cyc_cnt    = cyc_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_cpu_bus_sync.sv
// Bench for cpu_bus_sync: M2 pulses are turned into an expected per-edge event
// timeline from the latency rules, and every edge is compared against it.
module tb_cpu_bus_sync;
  import cpu_bus_pkg::*;

  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int WDLY = 4;
  localparam int LAT  = SYNC + FILT - 1;
  localparam int MAXE = 30000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m2_in = 1'b1;
  logic [15:0] cpu_addr_in = 16'h0000;
  logic [7:0]  cpu_dat_in = 8'h00;
  logic        cpu_rw_in = 1'b1;
  logic        m2_f;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic [7:0]  cpu_dat;
  logic        cyc_start, rd_stb, wr_stb, cyc_end;
  logic [15:0] cyc_cnt;
  logic [7:0]  glitch_cnt;

  cpu_bus_sync #(
    .SYNC_STAGES (SYNC),
    .M2_FILT     (FILT),
    .WR_DLY      (WDLY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m2_in       (m2_in),
    .cpu_addr_in (cpu_addr_in),
    .cpu_dat_in  (cpu_dat_in),
    .cpu_rw_in   (cpu_rw_in),
    .m2_f        (m2_f),
    .cpu_addr    (cpu_addr),
    .cpu_rw      (cpu_rw),
    .cpu_dat     (cpu_dat),
    .cyc_start   (cyc_start),
    .rd_stb      (rd_stb),
    .wr_stb      (wr_stb),
    .cyc_end     (cyc_end),
    .cyc_cnt     (cyc_cnt),
    .glitch_cnt  (glitch_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int eidx    = 0;

  // Expected events, indexed by absolute rising-edge number.
  bit          ev_start [MAXE];
  bit          ev_rd    [MAXE];
  bit          ev_wr    [MAXE];
  bit          ev_end   [MAXE];
  bit          ev_fset  [MAXE];
  bit          ev_fval  [MAXE];
  bit          ev_glitch[MAXE];
  logic [15:0] ev_addr  [MAXE];
  logic        ev_rw    [MAXE];
  logic [7:0]  ev_dat   [MAXE];

  // Model of the visible registers.
  logic        m_f    = 1'b1;
  logic [15:0] m_addr = 16'h0000;
  logic        m_rw   = 1'b1;
  logic [7:0]  m_dat  = 8'h00;
  logic [15:0] m_cnt  = 16'h0000;
  logic [7:0]  m_g    = 8'h00;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, act, exp, eidx);
    end
  endtask

  task automatic model_reset();
    m_f    = 1'b1;
    m_addr = 16'h0000;
    m_rw   = 1'b1;
    m_dat  = 8'h00;
    m_cnt  = 16'h0000;
    m_g    = 8'h00;
  endtask

  // Per-edge checker: apply expected events, then compare every output.
  initial begin
    logic [3:0] es;
    forever begin
      @(posedge clk);
      eidx++;
      #1;
      es = 4'b0000;
      if (rst_n && eidx < MAXE) begin
        es = {ev_start[eidx], ev_rd[eidx], ev_wr[eidx], ev_end[eidx]};
        if (ev_fset[eidx])  m_f = ev_fval[eidx];
        if (ev_start[eidx]) begin
          m_addr = ev_addr[eidx];
          m_rw   = ev_rw[eidx];
        end
        if (ev_wr[eidx])  m_dat = ev_dat[eidx];
        if (ev_end[eidx]) m_cnt = m_cnt + 16'd1;
        if (ev_glitch[eidx] && m_g != 8'hFF) m_g = m_g + 8'd1;
      end
      chk("strobes", 32'({cyc_start, rd_stb, wr_stb, cyc_end}), 32'(es));
      chk("m2_f", 32'(m2_f), 32'(m_f));
      chk("cpu_addr", 32'(cpu_addr), 32'(m_addr));
      chk("cpu_rw", 32'(cpu_rw), 32'(m_rw));
      chk("cpu_dat", 32'(cpu_dat), 32'(m_dat));
      chk("cyc_cnt", 32'(cyc_cnt), 32'(m_cnt));
      chk("glitch_cnt", 32'(glitch_cnt), 32'(m_g));
    end
  end

  // Called at a negedge with M2 currently high; drives it low for lo clocks.
  task automatic m2_fall(input int lo);
    int e0;
    m2_in = 1'b0;
    e0 = eidx + 1;
    if (e0 + LAT < MAXE) begin
      ev_fset[e0 + LAT] = 1'b1;
      ev_fval[e0 + LAT] = 1'b0;
    end
    repeat (lo) @(negedge clk);
  endtask

  // Called at a negedge with M2 low; one high phase of hi clocks, then lo clocks low.
  task automatic pulse(input int hi, input int lo, input logic [15:0] a,
                       input logic [7:0] d, input logic rw);
    int e0, r, fe, w;
    cpu_addr_in = a;
    cpu_dat_in  = d;
    cpu_rw_in   = rw;
    m2_in       = 1'b1;
    e0 = eidx + 1;
    if (hi >= FILT) begin
      r  = e0 + LAT;
      fe = e0 + hi + LAT;
      if (fe < MAXE) begin
        ev_fset[r]  = 1'b1;
        ev_fval[r]  = 1'b1;
        ev_start[r] = 1'b1;
        ev_addr[r]  = a;
        ev_rw[r]    = rw;
        ev_rd[r]    = rw;
        ev_fset[fe] = 1'b1;
        ev_fval[fe] = 1'b0;
        ev_end[fe]  = 1'b1;
        if (!rw) begin
          w = (hi > WDLY) ? r + WDLY : fe;
          ev_wr[w]  = 1'b1;
          ev_dat[w] = d;
        end
      end
    end else if (hi > 0 && e0 + SYNC + hi < MAXE) begin
      ev_glitch[e0 + SYNC + hi] = 1'b1;
    end
    repeat (hi) @(negedge clk);
    m2_in = 1'b0;
    repeat (FILT + 1) @(negedge clk);
    // scramble the bus while M2 is low; latched values must hold
    cpu_addr_in = 16'($urandom);
    cpu_dat_in  = 8'($urandom);
    cpu_rw_in   = 1'($urandom);
    repeat (lo - FILT - 1) @(negedge clk);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rst_m2_f", 32'(m2_f), 32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // partial cycle in progress at reset release, then one full read
    m2_fall(20);
    pulse(20, 20, 16'h8000, 8'h00, 1'b1);
    chk("read_addr", 32'(cpu_addr), 32'h8000);
    chk("read_cnt", 32'(cyc_cnt), 32'd1);

    pulse(20, 20, 16'h6123, 8'h5A, 1'b0);
    chk("write_dat", 32'(cpu_dat), 32'h5A);
    chk("write_rw", 32'(cpu_rw), 32'd0);

    // short writes: fall coincident with and before the delay match
    pulse(4, 12, 16'h6200, 8'hC3, 1'b0);
    chk("short_dat4", 32'(cpu_dat), 32'hC3);
    pulse(3, 12, 16'h6201, 8'h3C, 1'b0);
    chk("short_dat3", 32'(cpu_dat), 32'h3C);
    chk("short_cnt", 32'(cyc_cnt), 32'd4);

    pulse(2, 10, 16'h1111, 8'h11, 1'b1);
    chk("glitch_one", 32'(glitch_cnt), 32'd1);
    repeat (299) pulse(2, 8, 16'h2222, 8'h22, 1'b1);
    chk("glitch_sat", 32'(glitch_cnt), 32'd255);

    repeat (150) begin
      pulse(int'($urandom_range(24, 1)), int'($urandom_range(16, 8)),
            16'($urandom), 8'($urandom), 1'($urandom));
    end

    // preload the cycle counter just below wrap
    force dut.cyc_cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.cyc_cnt_q;
    pulse(10, 12, 16'hFFFC, 8'h00, 1'b1);
    chk("cnt_wrap", 32'(cyc_cnt), 32'd0);

    // reset during a write, before its sample point
    cpu_addr_in = 16'h1234;
    cpu_dat_in  = 8'hA5;
    cpu_rw_in   = 1'b0;
    m2_in       = 1'b1;
    e0 = eidx + 1;
    ev_fset[e0 + LAT]  = 1'b1;
    ev_fval[e0 + LAT]  = 1'b1;
    ev_start[e0 + LAT] = 1'b1;
    ev_addr[e0 + LAT]  = 16'h1234;
    ev_rw[e0 + LAT]    = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("midrst_dat", 32'(cpu_dat), 32'd0);
    chk("midrst_wr", 32'(wr_stb), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    m2_fall(12);
    pulse(20, 20, 16'h4020, 8'h00, 1'b1);
    chk("post_rst_cnt", 32'(cyc_cnt), 32'd1);
    chk("post_rst_addr", 32'(cpu_addr), 32'h4020);
    chk("post_rst_dat", 32'(cpu_dat), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
